// File: rtl/mv_mul_sched_if.sv
// Signal bundle between the warp-side requesters, the mv_mul datapath and the writeback
// consumer, as seen by the round-robin mv_mul scheduler.
interface mv_mul_sched_if #(
    parameter int NUM_REQ       = 4,
    parameter int SHAPE_M       = 8,
    parameter int SHAPE_N       = 8,
    parameter int ELEMENT_WIDTH = 9,
    parameter int DEPTH_WARP    = 4,
    parameter int TAG_DEPTH     = 4
);
    localparam int MAT_W = SHAPE_M * SHAPE_N * ELEMENT_WIDTH;
    localparam int VEC_W = SHAPE_N * ELEMENT_WIDTH;
    localparam int RES_W = SHAPE_M * ELEMENT_WIDTH;
    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [NUM_REQ*MAT_W-1:0]      req_a_i;
    logic [NUM_REQ*VEC_W-1:0]      req_b_i;
    logic [NUM_REQ*8-1:0]          req_reg_idxw_i;
    logic [NUM_REQ*DEPTH_WARP-1:0] req_warpid_i;

    logic [MAT_W-1:0]              mv_a_o;
    logic [VEC_W-1:0]              mv_b_o;
    logic                          mv_valid_o;
    logic                          mv_ready_i;
    logic                          mv_res_valid_i;
    logic                          mv_res_ready_o;
    logic [RES_W-1:0]              mv_result_i;
    logic [4:0]                    mv_fflags_i;

    logic                          rsp_valid_o;
    logic                          rsp_ready_i;
    logic [RES_W-1:0]              rsp_result_o;
    logic [4:0]                    rsp_fflags_o;
    logic [7:0]                    rsp_reg_idxw_o;
    logic [DEPTH_WARP-1:0]         rsp_warpid_o;
    logic [SRC_W-1:0]              rsp_src_o;
    logic [CNT_W-1:0]              inflight_o;
    logic                          err_o;

    modport slave (
        input  req_valid_i, req_a_i, req_b_i, req_reg_idxw_i, req_warpid_i,
        input  mv_ready_i, mv_res_valid_i, mv_result_i, mv_fflags_i, rsp_ready_i,
        output req_ready_o, mv_a_o, mv_b_o, mv_valid_o, mv_res_ready_o,
        output rsp_valid_o, rsp_result_o, rsp_fflags_o, rsp_reg_idxw_o, rsp_warpid_o,
        output rsp_src_o, inflight_o, err_o
    );

    modport master (
        output req_valid_i, req_a_i, req_b_i, req_reg_idxw_i, req_warpid_i,
        output mv_ready_i, mv_res_valid_i, mv_result_i, mv_fflags_i, rsp_ready_i,
        input  req_ready_o, mv_a_o, mv_b_o, mv_valid_o, mv_res_ready_o,
        input  rsp_valid_o, rsp_result_o, rsp_fflags_o, rsp_reg_idxw_o, rsp_warpid_o,
        input  rsp_src_o, inflight_o, err_o
    );
endinterface

// File: rtl/mv_mul_sched.sv
// Round-robin arbiter sharing one mv_mul datapath between NUM_REQ requesters; an in-order
// tag FIFO re-attaches {source, register, warp} to each result on its way to writeback.
module mv_mul_sched #(
    parameter int NUM_REQ       = 4,
    parameter int SHAPE_M       = 8,
    parameter int SHAPE_N       = 8,
    parameter int ELEMENT_WIDTH = 9,
    parameter int DEPTH_WARP    = 4,
    parameter int TAG_DEPTH     = 4
) (
    input logic           clk,
    input logic           rst_n,
    mv_mul_sched_if.slave bus
);
    localparam int MAT_W = SHAPE_M * SHAPE_N * ELEMENT_WIDTH;
    localparam int VEC_W = SHAPE_N * ELEMENT_WIDTH;
    localparam int RES_W = SHAPE_M * ELEMENT_WIDTH;
    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [SRC_W-1:0]      src;
        logic [7:0]            reg_idxw;
        logic [DEPTH_WARP-1:0] warpid;
    } tag_t;

    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] winner;
    logic [SRC_W:0]   idx_c;
    logic             found;
    logic             issue_free, grant, res_fire, pop, fifo_empty, fifo_full;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    tag_t             tag_mem [TAG_DEPTH];
    logic             err;

    logic [MAT_W-1:0] mv_a_p1;
    logic [VEC_W-1:0] mv_b_p1;
    logic             vld_p1;

    logic [RES_W-1:0] rsp_result_p2;
    logic [4:0]       rsp_fflags_p2;
    tag_t             rsp_tag_p2;
    logic             vld_p2;

    // Rotating priority: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx_c  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_c = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (idx_c >= (SRC_W+1)'(NUM_REQ)) idx_c = idx_c - (SRC_W+1)'(NUM_REQ);
            if (!found && bus.req_valid_i[idx_c[SRC_W-1:0]]) begin
                found  = 1'b1;
                winner = idx_c[SRC_W-1:0];
            end
        end
    end

    assign issue_free = !vld_p1 || bus.mv_ready_i;
    assign res_fire   = bus.mv_res_valid_i && bus.mv_res_ready_o;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(TAG_DEPTH));
    assign pop        = res_fire && !fifo_empty;
    // A full FIFO still grants when the head is popped in the same cycle.
    assign grant      = issue_free && (!fifo_full || pop) && found;

    always_comb begin
        bus.req_ready_o = '0;
        if (grant) bus.req_ready_o[winner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (grant) rr_ptr <= (winner == SRC_W'(NUM_REQ-1)) ? '0 : winner + SRC_W'(1);
            if (grant) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            if (grant && !pop)      count <= count + CNT_W'(1);
            else if (pop && !grant) count <= count - CNT_W'(1);
            if (res_fire && fifo_empty) err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            tag_mem[wr_ptr] <= '{src:      winner,
                                 reg_idxw: bus.req_reg_idxw_i[int'(winner)*8 +: 8],
                                 warpid:   bus.req_warpid_i[int'(winner)*DEPTH_WARP +: DEPTH_WARP]};
        end
    end

    // Stage p1: issue register towards mv_mul
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            mv_a_p1 <= '0;
            mv_b_p1 <= '0;
        end else if (issue_free) begin
            vld_p1 <= grant;
            if (grant) begin
                mv_a_p1 <= bus.req_a_i[int'(winner)*MAT_W +: MAT_W];
                mv_b_p1 <= bus.req_b_i[int'(winner)*VEC_W +: VEC_W];
            end
        end
    end

    // Stage p2: result register towards writeback, tag popped alongside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2        <= 1'b0;
            rsp_result_p2 <= '0;
            rsp_fflags_p2 <= '0;
            rsp_tag_p2    <= '0;
        end else if (pop) begin
            vld_p2        <= 1'b1;
            rsp_result_p2 <= bus.mv_result_i;
            rsp_fflags_p2 <= bus.mv_fflags_i;
            rsp_tag_p2    <= tag_mem[rd_ptr];
        end else if (bus.rsp_ready_i) begin
            vld_p2 <= 1'b0;
        end
    end

    assign bus.mv_a_o         = mv_a_p1;
    assign bus.mv_b_o         = mv_b_p1;
    assign bus.mv_valid_o     = vld_p1;
    assign bus.mv_res_ready_o = !vld_p2 || bus.rsp_ready_i;
    assign bus.rsp_valid_o    = vld_p2;
    assign bus.rsp_result_o   = rsp_result_p2;
    assign bus.rsp_fflags_o   = rsp_fflags_p2;
    assign bus.rsp_reg_idxw_o = rsp_tag_p2.reg_idxw;
    assign bus.rsp_warpid_o   = rsp_tag_p2.warpid;
    assign bus.rsp_src_o      = rsp_tag_p2.src;
    assign bus.inflight_o     = count;
    assign bus.err_o          = err;
endmodule

// File: doc/mv_mul_sched.md
# mv_mul_sched

Round-robin scheduler that lets up to NUM_REQ warp-side requesters share one `mv_mul` matrix-vector datapath. `mv_mul` does not carry control sideband through its pipeline, so this block holds an in-order tag FIFO of the metadata for each in-flight operation and re-attaches it to each returning result. It sits between the warp issue logic and `mv_mul`, and drives the writeback port.

## Interface
- `NUM_REQ`, 4: number of requesters (≥2).
- `SHAPE_M`, 8: matrix rows / result elements.
- `SHAPE_N`, 8: matrix columns / vector elements.
- `ELEMENT_WIDTH`, 9: element width.
- `DEPTH_WARP`, 4: warp-id width.
- `TAG_DEPTH`, 4: maximum in-flight operations; a power of 2, ≥2.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset; one clock; asynchronous, active-low.
- `req_valid_i` in NUM_REQ: per-requester request valid.
- `req_ready_o` out NUM_REQ: per-requester grant, one-hot or zero.
- `req_a_i` in NUM_REQ·M·N·EW: matrices; requester k occupies slice k.
- `req_b_i` in NUM_REQ·N·EW: vectors; requester k occupies slice k.
- `req_reg_idxw_i` in NUM_REQ·8: destination register per requester.
- `req_warpid_i` in NUM_REQ·DEPTH_WARP: warp id per requester.
- `mv_a_o` out M·N·EW: matrix to `mv_mul`.
- `mv_b_o` out N·EW: vector to `mv_mul`.
- `mv_valid_o` out 1: operand valid to `mv_mul`.
- `mv_ready_i` in 1: `mv_mul` ready to accept operands.
- `mv_res_valid_i` in 1: `mv_mul` result valid.
- `mv_res_ready_o` out 1: scheduler ready to accept a result.
- `mv_result_i` in M·EW: result vector from `mv_mul`.
- `mv_fflags_i` in 5: exception flags from `mv_mul`.
- `rsp_valid_o` out 1: writeback valid.
- `rsp_ready_i` in 1: writeback consumer ready.
- `rsp_result_o` out M·EW: result vector.
- `rsp_fflags_o` out 5: exception flags.
- `rsp_reg_idxw_o` out 8: destination register.
- `rsp_warpid_o` out DEPTH_WARP: warp id.
- `rsp_src_o` out clog2(NUM_REQ): index of the originating requester.
- `inflight_o` out clog2(TAG_DEPTH)+1: current tag FIFO occupancy.
- `err_o` out 1: sticky; set when a result returns with no outstanding tag.

## Operation
- **Issue register:** `mv_a_o`, `mv_b_o` and `mv_valid_o` are registered. The register is *free* when `!mv_valid_o || mv_ready_i`.
- **Grant condition:** grant occurs when the issue register is free, the tag FIFO is not full, and `req_valid_i` is nonzero.
- **Winner selection:** the winner is the first valid requester at or after `rr_ptr`, searching upward with wrap-around.
- **Grant effects:** `req_ready_o[winner]=1`, combinational. The winner's operands load into the issue register and `mv_valid_o` goes to 1. The tuple {winner, reg_idxw, warpid} is pushed into the tag FIFO. `rr_ptr` becomes `(winner+1) mod NUM_REQ`.
- **No grant while free:** `mv_valid_o` goes to 0 and `rr_ptr` holds.
- **Held handshake:** while `mv_valid_o && !mv_ready_i`, the issue register holds its contents and all `req_ready_o` are 0.
- **Result register:** `mv_res_ready_o = !rsp_valid_o || rsp_ready_i`.
- **Result capture:** when `mv_res_valid_i && mv_res_ready_o` and the FIFO is non-empty, the block captures the result and fflags, pops the head tag into `rsp_*`, and sets `rsp_valid_o` to 1. If `rsp_ready_i` is high with no new result, `rsp_valid_o` goes to 0.
- **Orphan result:** a result that arrives with the FIFO empty is accepted and dropped. `err_o` sets and stays set until reset.
- **Ordering:** results are strictly in grant order, because `mv_mul` is in-order.
- **Occupancy:** a push and a pop in the same cycle leave `inflight_o` unchanged. A push is accepted while full only if a pop happens in the same cycle; otherwise there is no grant. Pointers wrap modulo TAG_DEPTH.

## Timing
- **Reset values:** all outputs are 0; `rr_ptr`, FIFO pointers and count are 0; `err_o` is 0.
- **Reset mid-operation:** in-flight tags are discarded. Results returning after reset set `err_o`.
- **Issue latency:** a grant in cycle T gives `mv_valid_o=1` in T+1. Back-to-back grants are possible every cycle while `mv_ready_i=1`.
- **Response latency:** a result accepted in cycle R gives `rsp_valid_o` in R+1. Throughput is 1/cycle while `rsp_ready_i=1`.
- **Backpressure:** `rsp_ready_i=0` propagates to `mv_res_ready_o` combinationally in the same cycle. `rsp_*` stay stable while `rsp_valid_o && !rsp_ready_i`.
- **Stability:** `mv_a_o`/`mv_b_o` are stable while `mv_valid_o && !mv_ready_i`.

## Test plan
- **Single request:** after reset, requester 2 holds valid with reg 0x15 and warp 3; `mv_ready_i=1`; the stub returns the result 4 cycles later. Required: grant in cycle 0; `mv_valid_o` in cycle 1; `rsp_valid_o` with src 2, reg 0x15, warp 3; `inflight_o` returns to 0.
- **Round-robin fairness:** all 4 requesters valid continuously. Required: grant order 0,1,2,3,0,1 with one grant per cycle.
- **Full FIFO:** TAG_DEPTH=4 and the stub withholds results. Required: exactly 4 grants, then `req_ready_o=0` and `inflight_o=4`. One result return re-enables exactly one grant, and that grant falls in the same cycle as the pop.
- **Issue backpressure:** `mv_ready_i=0` for 5 cycles with a valid operand. Required: `mv_a_o` unchanged and no grants; exactly one transfer when `mv_ready_i` rises.
- **Response backpressure:** 3 in-flight results with `rsp_ready_i=0`. Required: `mv_res_ready_o=0` after the first capture and `rsp_*` held. On release, results come out in grant order with matching tags.
- **Orphan result:** `mv_res_valid_i=1` with the FIFO empty. Required: `err_o=1` from the next cycle on, no `rsp_valid_o`, and `err_o` clears only on `rst_n=0`.
